// File: rtl/matrix_scan_controller.sv
// Cell-matrix scan controller: walks N=ROWS*COLS cells one slot at a time and
// drives row/col lines plus H-bridge pairs. Optional macro: CELLS_SLOT_SKIP_EN.
//
// Ports: clock, reset_n (async, active low), enable_n (active-low run),
//   start, cells_state[N], ccr0/ccr1 (drive/slot compare), p_select_active,
//   clear_history, cell_invert -> busy, update_done, rows/cols, *_enable,
//   *_hbridge (2 bits per line).
module matrix_scan_controller #(
  parameter int ROWS  = 5,
  parameter int COLS  = 2,
  parameter int CNT_W = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable_n,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] cells_state,
  input  logic [CNT_W-1:0]     ccr0,
  input  logic [CNT_W-1:0]     ccr1,
  input  logic                 p_select_active,
  input  logic                 clear_history,
  input  logic                 cell_invert,
  output logic                 busy,
  output logic                 update_done,
  output logic [ROWS-1:0]      rows,
  output logic [COLS-1:0]      cols,
  output logic [ROWS-1:0]      rows_enable,
  output logic [COLS-1:0]      cols_enable,
  output logic [2*ROWS-1:0]    rows_hbridge,
  output logic [2*COLS-1:0]    cols_hbridge
);

  localparam int N  = ROWS * COLS;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [SW-1:0]   slot, slot_nx;
  logic            load;
  logic [N-1:0]    shadow, past, hv;
  logic            clr_pend;
  logic [N-1:0]    changed, cell_en;
  logic            drive;
  logic [ROWS-1:0] row_lvl, row_en, nr_lvl, nr_en;
  logic [COLS-1:0] col_lvl, col_en, nc_lvl, nc_en;

  assign changed = ~hv | (past ^ shadow);
  assign cell_en = changed | {N{~p_select_active}};

`ifdef CELLS_SLOT_SKIP_EN
  // {found, index} of the lowest set bit of v at or above from
  function automatic logic [SW:0] first_from(
    input logic [N-1:0] v,
    input int           from
  );
    logic [SW:0] res;
    res = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i >= from && v[i]) res = {1'b1, SW'(i)};
    return res;
  endfunction

  logic [N-1:0] hv_now, start_chg;
  logic [SW:0]  nf_start, nf_scan;
  // a clear issued with start must already count for this frame
  assign hv_now    = clear_history ? '0 : hv;
  assign start_chg = ~hv_now | (past ^ cells_state);
  assign nf_start  = first_from(start_chg, 0);
  assign nf_scan   = first_from(changed, int'(slot) + 1);
`endif

  always_comb begin
    state_nx = state;
    count_nx = count;
    slot_nx  = slot;
    load     = 1'b0;
    if (enable_n) begin
      state_nx = IDLE;
      count_nx = '0;
      slot_nx  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            load     = 1'b1;
            state_nx = SCAN;
            count_nx = '0;
            slot_nx  = '0;
`ifdef CELLS_SLOT_SKIP_EN
            if (p_select_active) begin
              if (nf_start[SW]) slot_nx = nf_start[SW-1:0];
              else state_nx = DONE;
            end
`endif
          end
        end
        SCAN: begin
          count_nx = count + CNT_W'(1);
          if (count >= ccr1) begin
            count_nx = '0;
            if (slot == LAST) state_nx = DONE;
            else slot_nx = slot + SW'(1);
`ifdef CELLS_SLOT_SKIP_EN
            if (p_select_active) begin
              if (nf_scan[SW]) begin
                state_nx = SCAN;
                slot_nx  = nf_scan[SW-1:0];
              end else begin
                state_nx = DONE;
                slot_nx  = slot;
              end
            end
`endif
          end
        end
        DONE: begin
          state_nx = IDLE;
          count_nx = '0;
          slot_nx  = '0;
        end
        default: begin
          state_nx = IDLE;
          count_nx = '0;
          slot_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      slot  <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      slot  <= slot_nx;
    end
  end

  // Shadow and history; a clear seen mid-frame waits for the return to IDLE
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow   <= '0;
      past     <= '0;
      hv       <= '0;
      clr_pend <= 1'b0;
    end else begin
      if (load) shadow <= cells_state;
      if (state == IDLE) begin
        if (clear_history) hv <= '0;
        clr_pend <= 1'b0;
      end else if (state_nx == IDLE) begin
        if (state == DONE && !enable_n) past <= shadow;
        if (clr_pend || clear_history) hv <= '0;
        else if (state == DONE && !enable_n) hv <= '1;
        clr_pend <= 1'b0;
      end else if (clear_history) begin
        clr_pend <= 1'b1;
      end
    end
  end

  assign drive = !enable_n && state == SCAN && count <= ccr0;

  always_comb begin
    int r;
    int c;
    r = int'(slot) % ROWS;
    c = int'(slot) / ROWS;
    for (int i = 0; i < ROWS; i++) begin
      nr_en[i]  = drive && i == r && cell_en[slot];
      nr_lvl[i] = drive && i == r && shadow[slot];
    end
    for (int i = 0; i < COLS; i++) begin
      nc_en[i]  = drive && i == c && cell_en[slot];
      nc_lvl[i] = drive && i == c && !shadow[slot];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_en  <= '0;
      row_lvl <= '0;
      col_en  <= '0;
      col_lvl <= '0;
    end else begin
      row_en  <= nr_en;
      row_lvl <= nr_lvl;
      col_en  <= nc_en;
      col_lvl <= nc_lvl;
    end
  end

  assign busy        = (state == SCAN) || (state == DONE);
  assign update_done = (state == DONE);
  assign rows        = row_lvl ^ {ROWS{cell_invert}};
  assign cols        = col_lvl ^ {COLS{cell_invert}};
  assign rows_enable = row_en;
  assign cols_enable = col_en;

  always_comb begin
    for (int i = 0; i < ROWS; i++)
      rows_hbridge[2*i +: 2] = row_en[i] ? (rows[i] ? 2'b11 : 2'b00) : 2'b10;
    for (int i = 0; i < COLS; i++)
      cols_hbridge[2*i +: 2] = col_en[i] ? (cols[i] ? 2'b11 : 2'b00) : 2'b10;
  end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Bench for matrix_scan_controller: table of whole frames on a 5x2 instance
// plus hand sequences (invert, abort, 4x3 one-cycle slots).
module tb_matrix_scan_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  cells_state = '0;
  logic [31:0] ccr0 = 32'd1;
  logic [31:0] ccr1 = 32'd3;
  logic        p_select_active = 1'b0;
  logic        clear_history = 1'b0;
  logic        cell_invert = 1'b0;
  logic        busy, update_done;
  logic [4:0]  rows, rows_enable;
  logic [1:0]  cols, cols_enable;
  logic [9:0]  rows_hbridge;
  logic [3:0]  cols_hbridge;

  logic        start2 = 1'b0;
  logic [11:0] cells2 = '0;
  logic        busy2, done2;
  logic [3:0]  rows2, rows_en2;
  logic [2:0]  cols2, cols_en2;
  logic [7:0]  rows_hb2;
  logic [5:0]  cols_hb2;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  matrix_scan_controller dut (
    .clock(clock), .reset_n(reset_n), .enable_n(enable_n),
    .start(start), .cells_state(cells_state),
    .ccr0(ccr0), .ccr1(ccr1),
    .p_select_active(p_select_active),
    .clear_history(clear_history), .cell_invert(cell_invert),
    .busy(busy), .update_done(update_done),
    .rows(rows), .cols(cols),
    .rows_enable(rows_enable), .cols_enable(cols_enable),
    .rows_hbridge(rows_hbridge), .cols_hbridge(cols_hbridge)
  );

  matrix_scan_controller #(.ROWS(4), .COLS(3), .CNT_W(8)) dut2 (
    .clock(clock), .reset_n(reset_n), .enable_n(1'b0),
    .start(start2), .cells_state(cells2),
    .ccr0(8'd0), .ccr1(8'd0),
    .p_select_active(1'b0),
    .clear_history(1'b0), .cell_invert(1'b0),
    .busy(busy2), .update_done(done2),
    .rows(rows2), .cols(cols2),
    .rows_enable(rows_en2), .cols_enable(cols_en2),
    .rows_hbridge(rows_hb2), .cols_hbridge(cols_hb2)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // clr: 0 none, 1 pulse in IDLE before start, 2 pulse mid-frame
  task automatic run_frame(input logic [9:0] cells, input logic psel,
                           input int clr, input logic [9:0] exp_en);
    logic [9:0] obs_en;
    logic [9:0] obs_lvl;
    int drv;
    int len;
    int r;
    int c;
    obs_en = '0;
    obs_lvl = '0;
    drv = 0;
    len = 0;
    @(negedge clock);
    cells_state = cells;
    p_select_active = psel;
    if (clr == 1) begin
      clear_history = 1'b1;
      @(negedge clock);
      clear_history = 1'b0;
    end
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clock);
      if (t == 1) chk("busy_t1", busy, 1);
      if (|rows_enable) drv++;
      if ($countones(rows_enable) == 1 && $countones(cols_enable) == 1) begin
        r = 0;
        c = 0;
        for (int i = 0; i < 5; i++) if (rows_enable[i]) r = i;
        for (int i = 0; i < 2; i++) if (cols_enable[i]) c = i;
        obs_en[c*5+r] = 1'b1;
        obs_lvl[c*5+r] = rows[r];
      end
      if (update_done) begin
        len = t;
        break;
      end
      if (t == 5) begin
        cells_state = ~cells;
        start = 1'b1;
      end
      if (t == 6) start = 1'b0;
      if (clr == 2 && t == 10) clear_history = 1'b1;
      if (clr == 2 && t == 11) clear_history = 1'b0;
    end
    chk("frame_len", len, 41);
    @(negedge clock);
    chk("done_one_cycle", update_done, 0);
    chk("idle_after", busy, 0);
    chk("enabled_cells", obs_en, exp_en);
    chk("cell_levels", obs_lvl, cells & exp_en);
    chk("drive_cycles", drv, 2 * $countones(exp_en));
  endtask

  typedef struct {
    logic [9:0] cells;
    logic       psel;
    int         clr;
    logic [9:0] exp_en;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int seen;
    int len2;

    tbl[0] = '{10'h3FF, 1'b0, 0, 10'h3FF};
    tbl[1] = '{10'h3FF, 1'b1, 0, 10'h000};
    tbl[2] = '{10'h080, 1'b1, 0, 10'h37F};
    tbl[3] = '{10'h080, 1'b1, 1, 10'h3FF};
    tbl[4] = '{10'h155, 1'b0, 2, 10'h3FF};
    tbl[5] = '{10'h155, 1'b1, 0, 10'h3FF};
    tbl[6] = '{10'h155, 1'b1, 0, 10'h000};

    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", update_done, 0);
    chk("rst_row_en", rows_enable, 0);
    chk("rst_col_en", cols_enable, 0);
    chk("rst_rows", rows, 0);
    chk("rst_cols", cols, 0);
    chk("rst_row_hb", rows_hbridge, 10'h2AA);
    chk("rst_col_hb", cols_hbridge, 4'hA);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_frame(tbl[i].cells, tbl[i].psel, tbl[i].clr, tbl[i].exp_en);

    // inverted levels on slot 7 (row 2, col 1)
    @(negedge clock);
    cells_state = 10'h080;
    p_select_active = 1'b0;
    cell_invert = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    seen = 0;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clock);
      if (t == 30) begin
        chk("inv_row_hb", rows_hbridge, 10'b10_10_00_10_10);
        chk("inv_col_hb", cols_hbridge, 4'b11_10);
        chk("inv_rows", rows, 5'b11011);
      end
      if (update_done) begin
        seen = t;
        break;
      end
    end
    chk("inv_len", seen, 41);
    @(negedge clock);
    cell_invert = 1'b0;

    // abort during slot 4
    cells_state = 10'h2AA;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int t = 1; t <= 17; t++) @(negedge clock);
    enable_n = 1'b1;
    @(negedge clock);
    chk("abort_row_hb", rows_hbridge, 10'h2AA);
    chk("abort_col_hb", cols_hbridge, 4'hA);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge clock);
    enable_n = 1'b0;
    seen = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clock);
      if (update_done) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_frame(10'h2AA, 1'b1, 0, 10'h22A);

    // 4x3 instance, one-cycle slots
    @(negedge clock);
    cells2 = 12'h800;
    start2 = 1'b1;
    @(posedge clock);
    #1 start2 = 1'b0;
    len2 = 0;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clock);
      if (t == 12) begin
        chk("g2_t12_row_en", rows_en2, 4'b0100);
        chk("g2_t12_col_en", cols_en2, 3'b100);
        chk("g2_t12_cols", cols2, 3'b100);
      end
      if (t == 13) begin
        chk("g2_c11_row_en", rows_en2, 4'b1000);
        chk("g2_c11_col_en", cols_en2, 3'b100);
        chk("g2_c11_rows", rows2, 4'b1000);
        chk("g2_c11_cols", cols2, 3'b000);
      end
      if (done2) begin
        len2 = t;
        break;
      end
    end
    chk("g2_len", len2, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_scan_controller.md
MATRIX_SCAN_CONTROLLER -- requirements
Module: matrix_scan_controller

Interface
REQ-001 SHALL have parameter ROWS, default 5, number of row lines.
REQ-002 SHALL have parameter COLS, default 2, number of column lines; N = ROWS*COLS cells.
REQ-003 SHALL have parameter CNT_W, default 32, width of slot timer and compare registers.
REQ-004 SHALL have ports:
- clock, in, 1: sole clock, rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- enable_n, in, 1: active-low run enable.
- start, in, 1: frame request pulse.
- cells_state, in, N: target level per cell.
- ccr0, in, CNT_W: last drive count in a slot.
- ccr1, in, CNT_W: last count in a slot (slot length ccr1+1).
- p_select_active, in, 1: drive changed cells only.
- clear_history, in, 1: invalidate past-state memory.
- cell_invert, in, 1: invert row/col levels.
- busy, out, 1: frame in progress.
- update_done, out, 1: one-cycle frame-complete pulse.
- rows / cols, out, ROWS / COLS: drive levels.
- rows_enable / cols_enable, out, ROWS / COLS: line enables.
- rows_hbridge / cols_hbridge, out, 2*ROWS / 2*COLS: H-bridge pairs.

Function
REQ-005 SHALL map cell k to row k%ROWS, col k/ROWS; scan order k = 0..N-1.
REQ-006 SHALL implement FSM IDLE->SCAN->DONE->IDLE; start in IDLE with enable_n=0 latches cells_state into a shadow register and enters SCAN at slot 0, count 0.
REQ-007 SHALL, in SCAN, increment count each cycle; at count==ccr1 reset count to 0 and advance slot; after slot N-1 enter DONE.
REQ-008 SHALL assert update_done for exactly the DONE cycle, copy shadow into past-state memory and set all history-valid bits, then return to IDLE.
REQ-009 SHALL ignore start while busy; cells_state changes during SCAN SHALL not affect the frame.
REQ-010 SHALL flag cell k changed when its history-valid bit is 0 or past-state differs from shadow; cell_en(k) = changed(k) | ~p_select_active.
REQ-011 SHALL register outputs one cycle after the count: for slot k with count <= ccr0, row r and col c of cell k get enable = cell_en(k), row level = shadow(k), col level = ~shadow(k); all other lines enable 0, level 0.
REQ-012 SHALL XOR all row/col levels with cell_invert (combinational, after registers).
REQ-013 SHALL encode each hbridge pair as enable ? (level ? 2'b11 : 2'b00) : 2'b10.
REQ-014 SHALL treat ccr1=0 as one-cycle slots and ccr0>=ccr1 as drive for the whole slot.
REQ-015 SHALL abort to IDLE on enable_n=1 in any state within one cycle: enables 0, no update_done, memory unchanged; enable_n=1 overrides simultaneous start.
REQ-016 SHALL clear all history-valid bits on clear_history in IDLE; in other states the clear SHALL be applied on return to IDLE, overriding the REQ-008 set.
REQ-017 SHALL drive busy=1 in SCAN and DONE.

Reset
REQ-018 SHALL on reset_n=0 force IDLE, count 0, slot 0, busy 0, update_done 0, all rows/cols/enables 0 pre-inversion, history-valid bits 0, shadow 0.

Configuration
REQ-019 SHALL, with CELLS_SLOT_SKIP_EN defined and p_select_active=1, jump directly to the next changed slot (DONE if none), so unchanged cells consume no time; without the macro, unchanged slots dwell full ccr1+1 cycles with enables 0.

Verification
REQ-020 Reset, cells_state=10'h3FF, ccr0=1, ccr1=3, start -> 10 slots x 4 cycles, each cell's row enable high 2 cycles, update_done pulse 41 cycles after start.
REQ-021 Same frame repeated with p_select_active=1 -> all enables 0 throughout (macro off) / update_done one cycle after start (macro on).
REQ-022 Cell 7=1, cell_invert=1 -> slot 7: rows_hbridge[5:4]=2'b00, cols_hbridge[3:2]=2'b11; idle lines 2'b10.
REQ-023 enable_n=1 at slot 4 -> all hbridge pairs 2'b10 next cycle, no update_done, next frame still drives all changed cells.
REQ-024 clear_history then identical frame with p_select_active=1 -> all 10 cells enabled.
REQ-025 ROWS=4, COLS=3 build, ccr1=0 -> 12 one-cycle slots, cell 11 on row 3 col 2.
